stall_ctrl: RTL and testbench

//  Next-generation pipeline stall controller for the 5-stage CPU, placed between F/D and D/X.

---
 rtl/stall_ctrl.sv | 175 +++++++++++++++++
 tb/tb_stall_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/stall_ctrl.sv
// stall_ctrl -- pipeline stall controller sitting between F/D and D/X.
//
// Purpose:
//   Detects load-use hazards and holds the stall for LOAD_LAT bubbles.
//   Tracks an in-flight multi-cycle mult/div with an IDLE/BUSY/WB FSM and
//   a destination tag. Drives the PC/FD write enables and the DX bubble mux.
//
// Ports:
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   fd_opcode/fd_rs/fd_rt   instruction in FD (opcode, source registers)
//   fd_is_md                FD instruction is a mult/div
//   dx_opcode/dx_rd         instruction in DX (opcode, destination)
//   md_issue/md_rd          mult/div launched from DX this cycle, its dest
//   md_ready                mult/div result valid (1-cycle pulse)
//   flush                   branch flush, cancels pending load bubbles
//   fd_we, pc_we            FD latch / PC write enables
//   dx_mux_control          1 = inject a nop into DX
//   md_busy                 FSM is in BUSY
//   md_timeout              1-cycle pulse after a BUSY timeout
//   stall_cycles            stall performance counter
//
// Build option:
//   STALL_PERF_CNT_EN  when defined, stall_cycles counts (saturating) every
//                      clock with dx_mux_control=1; otherwise it is tied to 0.

module stall_ctrl #(
  parameter int unsigned          REG_W       = 5,
  parameter int unsigned          OPC_W       = 5,
  parameter logic [OPC_W-1:0]     LW_OPC      = 5'b01000,
  parameter logic [OPC_W-1:0]     SW_OPC      = 5'b00111,
  parameter int unsigned          LOAD_LAT    = 1,
  parameter bit                   MD_BLOCKING = 1'b1,
  parameter int unsigned          MD_TIMEOUT  = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [OPC_W-1:0] fd_opcode,
  input  logic [REG_W-1:0] fd_rs,
  input  logic [REG_W-1:0] fd_rt,
  input  logic             fd_is_md,
  input  logic [OPC_W-1:0] dx_opcode,
  input  logic [REG_W-1:0] dx_rd,
  input  logic             md_issue,
  input  logic [REG_W-1:0] md_rd,
  input  logic             md_ready,
  input  logic             flush,
  output logic             fd_we,
  output logic             pc_we,
  output logic             dx_mux_control,
  output logic             md_busy,
  output logic             md_timeout,
  output logic [31:0]      stall_cycles
);

  localparam logic [1:0]        LU_RELOAD = 2'(LOAD_LAT - 1);
  localparam int unsigned       CYC_W     = $clog2(MD_TIMEOUT + 1);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_WB
  } md_state_e;

  md_state_e        state_q, state_d;
  logic [1:0]       lu_cnt_q, lu_cnt_d;
  logic [REG_W-1:0] md_tag_q, md_tag_d;
  logic [CYC_W-1:0] md_cyc_q, md_cyc_d;
  logic             md_timeout_q, md_timeout_d;

  logic lu_hit, lu_stall, md_dep, md_stall;

  // Load-use detection: a store's rt is a source only when it is read, and
  // the store's rt is the data, which the bypass handles, so it is excluded.
  assign lu_hit = (dx_opcode == LW_OPC) && (dx_rd != '0) &&
                  ((fd_rs == dx_rd) || ((fd_rt == dx_rd) && (fd_opcode != SW_OPC)));

  assign md_dep = fd_is_md ||
                  ((md_tag_q != '0) &&
                   ((fd_rs == md_tag_q) || ((fd_rt == md_tag_q) && (fd_opcode != SW_OPC))));

  // The hit cycle itself is a bubble, so the counter only covers the
  // remaining LOAD_LAT-1; a hit while counting does not extend the stall.
  always_comb begin
    lu_cnt_d = lu_cnt_q;
    if (flush) begin
      lu_cnt_d = '0;
    end else if (lu_hit && (lu_cnt_q == '0)) begin
      lu_cnt_d = LU_RELOAD;
    end else if (lu_cnt_q != '0) begin
      lu_cnt_d = lu_cnt_q - 2'd1;
    end
  end

  assign lu_stall = lu_hit || (lu_cnt_q != '0);

  always_comb begin
    state_d      = state_q;
    md_tag_d     = md_tag_q;
    md_cyc_d     = md_cyc_q;
    md_timeout_d = 1'b0;
    md_stall     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (md_issue) begin
          state_d  = ST_BUSY;
          md_tag_d = md_rd;
          md_cyc_d = '0;
        end
      end
      ST_BUSY: begin
        md_cyc_d = md_cyc_q + CYC_W'(1);
        md_stall = MD_BLOCKING ? 1'b1 : md_dep;
        // md_ready takes priority over a timeout in the same cycle
        if (md_ready) begin
          state_d = ST_WB;
        end else if (md_cyc_q == CYC_LAST) begin
          state_d      = ST_IDLE;
          md_timeout_d = 1'b1;
        end
      end
      ST_WB: begin
        if (md_issue) begin
          state_d  = ST_BUSY;
          md_tag_d = md_rd;
          md_cyc_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      lu_cnt_q     <= '0;
      md_tag_q     <= '0;
      md_cyc_q     <= '0;
      md_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lu_cnt_q     <= lu_cnt_d;
      md_tag_q     <= md_tag_d;
      md_cyc_q     <= md_cyc_d;
      md_timeout_q <= md_timeout_d;
    end
  end

  // Detection is combinational, so gate with reset_n to hold the pipeline
  // enabled while reset is asserted.
  assign dx_mux_control = reset_n && (lu_stall || md_stall);
  assign fd_we          = ~dx_mux_control;
  assign pc_we          = ~dx_mux_control;
  assign md_busy        = (state_q == ST_BUSY);
  assign md_timeout     = md_timeout_q;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_q <= '0;
    end else if (dx_mux_control && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed testbench for stall_ctrl. Two instances share stimulus:
//   u_lat3: LOAD_LAT=3, MD_BLOCKING=0, MD_TIMEOUT=8
//   u_lat1: LOAD_LAT=1, MD_BLOCKING=1, MD_TIMEOUT=64
module tb_stall_ctrl;

  localparam logic [4:0] LW = 5'b01000;
  localparam logic [4:0] SW = 5'b00111;

  logic       clock, reset_n;
  logic [4:0] fd_opcode, fd_rs, fd_rt, dx_opcode, dx_rd, md_rd;
  logic       fd_is_md, md_issue, md_ready, flush;

  logic        l3_fdwe, l3_pcwe, l3_mux, l3_busy, l3_to;
  logic [31:0] l3_perf;
  logic        l1_fdwe, l1_pcwe, l1_mux, l1_busy, l1_to;
  logic [31:0] l1_perf;

  int n_vec = 0;
  int n_err = 0;

  stall_ctrl #(.LOAD_LAT(3), .MD_BLOCKING(1'b0), .MD_TIMEOUT(8)) u_lat3 (
    .clock(clock), .reset_n(reset_n),
    .fd_opcode(fd_opcode), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_is_md(fd_is_md),
    .dx_opcode(dx_opcode), .dx_rd(dx_rd),
    .md_issue(md_issue), .md_rd(md_rd), .md_ready(md_ready), .flush(flush),
    .fd_we(l3_fdwe), .pc_we(l3_pcwe), .dx_mux_control(l3_mux),
    .md_busy(l3_busy), .md_timeout(l3_to), .stall_cycles(l3_perf)
  );

  stall_ctrl #(.LOAD_LAT(1), .MD_BLOCKING(1'b1), .MD_TIMEOUT(64)) u_lat1 (
    .clock(clock), .reset_n(reset_n),
    .fd_opcode(fd_opcode), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_is_md(fd_is_md),
    .dx_opcode(dx_opcode), .dx_rd(dx_rd),
    .md_issue(md_issue), .md_rd(md_rd), .md_ready(md_ready), .flush(flush),
    .fd_we(l1_fdwe), .pc_we(l1_pcwe), .dx_mux_control(l1_mux),
    .md_busy(l1_busy), .md_timeout(l1_to), .stall_cycles(l1_perf)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] perf_exp(input int unsigned n);
`ifdef STALL_PERF_CNT_EN
    return 32'(n);
`else
    return 32'(n & 0);
`endif
  endfunction

  task automatic idle();
    fd_opcode = '0; fd_rs = 5'd1; fd_rt = 5'd2; fd_is_md = 1'b0;
    dx_opcode = '0; dx_rd = '0;
    md_issue = 1'b0; md_rd = '0; md_ready = 1'b0; flush = 1'b0;
  endtask

  // advance to just after the next rising edge; inputs are then driven and
  // outputs checked #1 later, well clear of the following edge
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic lw_hit_rs5();
    idle();
    dx_opcode = LW; dx_rd = 5'd5; fd_rs = 5'd5;
  endtask

  initial begin
    // reset, with a load-use hit present: outputs must still be forced
    reset_n = 1'b0;
    lw_hit_rs5();
    #3;
    chk("rst_mux",   l3_mux,  1'b0);
    chk("rst_fdwe",  l3_fdwe, 1'b1);
    chk("rst_pcwe",  l3_pcwe, 1'b1);
    chk("rst_busy",  l3_busy, 1'b0);
    chk("rst_to",    l3_to,   1'b0);
    chk("rst_perf",  l3_perf, 32'd0);
    chk("rst_mux1",  l1_mux,  1'b0);
    idle();
    @(negedge clock);
    reset_n = 1'b1;

    // T1/T3: single load-use hit, 1 vs 3 bubbles
    cyc(); lw_hit_rs5(); #1;
    chk("t1_mux1",  l1_mux,  1'b1);
    chk("t1_fdwe1", l1_fdwe, 1'b0);
    chk("t1_pcwe1", l1_pcwe, 1'b0);
    chk("t1_mux3",  l3_mux,  1'b1);
    cyc(); idle(); #1;
    chk("t1_rel1",  l1_mux,  1'b0);
    chk("t1_we1",   l1_fdwe, 1'b1);
    chk("t3_b2",    l3_mux,  1'b1);
    cyc(); idle(); #1;
    chk("t3_b3",    l3_mux,  1'b1);
    cyc(); idle(); #1;
    chk("t3_rel",   l3_mux,  1'b0);
    chk("t3_we",    l3_fdwe, 1'b1);

    // T2: store rt not a dependence; non-store rt is; r0 never hazards
    cyc(); idle(); dx_opcode = LW; dx_rd = 5'd5; fd_rt = 5'd5; fd_opcode = SW; #1;
    chk("t2_sw3", l3_mux, 1'b0);
    chk("t2_sw1", l1_mux, 1'b0);
    cyc(); idle(); dx_opcode = LW; dx_rd = 5'd5; fd_rt = 5'd5; #1;
    chk("t2_rt3", l3_mux, 1'b1);
    chk("t2_rt1", l1_mux, 1'b1);
    cyc(); idle(); #1;
    chk("t2_rt3b", l3_mux, 1'b1);
    chk("t2_rt1b", l1_mux, 1'b0);
    cyc(); idle(); #1;
    chk("t2_rt3c", l3_mux, 1'b1);
    cyc(); idle(); dx_opcode = LW; dx_rd = '0; fd_rs = '0; fd_rt = '0; #1;
    chk("t2_r0_3", l3_mux, 1'b0);
    chk("t2_r0_1", l1_mux, 1'b0);

    // T3: flush on the second bubble cancels the rest
    cyc(); lw_hit_rs5(); #1;
    chk("t3f_b1", l3_mux, 1'b1);
    cyc(); idle(); flush = 1'b1; #1;
    chk("t3f_b2", l3_mux, 1'b1);
    chk("t3f_l1", l1_mux, 1'b0);
    cyc(); idle(); #1;
    chk("t3f_rel", l3_mux, 1'b0);

    // repeated hit while counting must not reload the counter
    cyc(); lw_hit_rs5(); #1;
    chk("rh_b1", l3_mux, 1'b1);
    cyc(); lw_hit_rs5(); #1;
    chk("rh_b2",  l3_mux, 1'b1);
    chk("rh_l1",  l1_mux, 1'b1);
    cyc(); idle(); #1;
    chk("rh_b3", l3_mux, 1'b1);
    cyc(); idle(); #1;
    chk("rh_rel", l3_mux, 1'b0);
    chk("perf_a3", l3_perf, perf_exp(11));
    chk("perf_a1", l1_perf, perf_exp(5));

    // T4: mult/div to r7, dependent-only (u_lat3) vs blocking (u_lat1)
    cyc(); idle(); md_issue = 1'b1; md_rd = 5'd7; #1;
    chk("t4_idle_busy", l3_busy, 1'b0);
    chk("t4_idle_mux",  l3_mux,  1'b0);
    cyc(); idle(); fd_rs = 5'd3; #1;
    chk("t4_busy3",   l3_busy, 1'b1);
    chk("t4_indep3",  l3_mux,  1'b0);
    chk("t4_busy1",   l1_busy, 1'b1);
    chk("t4_block1",  l1_mux,  1'b1);
    cyc(); idle(); fd_rs = 5'd7; #1;
    chk("t4_rs_dep",  l3_mux, 1'b1);
    cyc(); idle(); fd_rt = 5'd7; fd_opcode = SW; #1;
    chk("t4_sw_rt",   l3_mux, 1'b0);
    cyc(); idle(); fd_rt = 5'd7; #1;
    chk("t4_rt_dep",  l3_mux, 1'b1);
    cyc(); idle(); fd_is_md = 1'b1; #1;
    chk("t4_is_md",   l3_mux, 1'b1);
    cyc(); idle(); fd_rs = 5'd7; md_ready = 1'b1; #1;
    chk("t4_rdy_mux",  l3_mux,  1'b1);
    chk("t4_rdy_busy", l3_busy, 1'b1);
    cyc(); idle(); fd_rs = 5'd7; #1;
    chk("t4_wb_busy",  l3_busy, 1'b0);
    chk("t4_wb_mux",   l3_mux,  1'b0);
    chk("t4_wb_fdwe",  l3_fdwe, 1'b1);
    chk("t4_wb_busy1", l1_busy, 1'b0);
    chk("t4_wb_mux1",  l1_mux,  1'b0);
    cyc(); idle(); fd_rs = 5'd7; #1;
    chk("t4_idle2", l3_busy, 1'b0);
    chk("t4_idle2m", l3_mux, 1'b0);

    // T5: timeout after 8 BUSY cycles
    cyc(); idle(); md_issue = 1'b1; md_rd = 5'd7; #1;
    chk("t5_pre", l3_busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(); idle(); #1;
      chk($sformatf("t5_busy%0d", i), l3_busy, 1'b1);
      chk($sformatf("t5_to%0d", i),   l3_to,   1'b0);
    end
    cyc(); idle(); #1;
    chk("t5_exit_busy", l3_busy, 1'b0);
    chk("t5_pulse",     l3_to,   1'b1);
    chk("t5_exit_mux",  l3_mux,  1'b0);
    cyc(); idle(); #1;
    chk("t5_pulse_end", l3_to, 1'b0);
    chk("perf_b3", l3_perf, perf_exp(15));

    // md_ready on the timeout cycle wins; md_issue in WB is accepted
    cyc(); idle(); md_issue = 1'b1; md_rd = 5'd7;
    for (int i = 0; i < 7; i++) begin
      cyc(); idle();
    end
    cyc(); idle(); md_ready = 1'b1; #1;
    chk("rw_last_busy", l3_busy, 1'b1);
    cyc(); idle(); md_issue = 1'b1; md_rd = 5'd9; #1;
    chk("rw_wb_busy", l3_busy, 1'b0);
    chk("rw_no_to",   l3_to,   1'b0);
    cyc(); idle(); fd_rs = 5'd9; #1;
    chk("wb_issue_busy", l3_busy, 1'b1);
    chk("wb_issue_to",   l3_to,   1'b0);
    chk("wb_issue_dep",  l3_mux,  1'b1);

    // T6: reset during BUSY
    reset_n = 1'b0; #1;
    chk("t6_fdwe",  l3_fdwe, 1'b1);
    chk("t6_mux",   l3_mux,  1'b0);
    chk("t6_busy",  l3_busy, 1'b0);
    chk("t6_perf",  l3_perf, 32'd0);
    chk("t6_perf1", l1_perf, 32'd0);
    chk("t6_fdwe1", l1_fdwe, 1'b1);
    @(negedge clock);
    reset_n = 1'b1;
    cyc(); idle(); fd_rs = 5'd9; #1;
    chk("t6_post_busy", l3_busy, 1'b0);
    chk("t6_post_mux",  l3_mux,  1'b0);

    // five stall cycles on u_lat3 (3 + 2 with flush), two on u_lat1
    cyc(); lw_hit_rs5();
    cyc(); idle();
    cyc(); idle();
    cyc(); lw_hit_rs5();
    cyc(); idle(); flush = 1'b1;
    cyc(); idle(); #1;
    chk("t6_stalls_mux", l3_mux, 1'b0);
    chk("t6_perf5",  l3_perf, perf_exp(5));
    chk("t6_perf2",  l1_perf, perf_exp(2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
